tb_mem_multiport: RTL and testbench



---
 rtl/tb_mem_multiport.sv | 136 +++++++++++++
 tb/tb_tb_mem_multiport.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_mem_multiport.sv
// tb_mem_multiport: shared word array behind NrPorts round-robin request ports,
// each with a fixed-latency pipeline and a credit-limited FWFT response FIFO.
module tb_mem_multiport #(
    parameter int unsigned              NrPorts   = 2,
    parameter int unsigned              AddrWidth = 32,
    parameter int unsigned              DataWidth = 64,
    parameter int unsigned              NumWords  = 1024,
    parameter logic [AddrWidth-1:0]     BaseAddr  = AddrWidth'(32'h8000_0000),
    parameter int unsigned              Latency   = 2,
    parameter int unsigned              RspDepth  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NrPorts-1:0]               q_valid_i,
    output logic [NrPorts-1:0]               q_ready_o,
    input  logic [NrPorts*AddrWidth-1:0]     q_addr_i,
    input  logic [NrPorts-1:0]               q_write_i,
    input  logic [NrPorts*DataWidth-1:0]     q_data_i,
    input  logic [NrPorts*DataWidth/8-1:0]   q_strb_i,
    output logic [NrPorts-1:0]               p_valid_o,
    input  logic [NrPorts-1:0]               p_ready_i,
    output logic [NrPorts*DataWidth-1:0]     p_data_o,
    output logic [NrPorts-1:0]               p_error_o
);
    localparam int StrbW = DataWidth / 8;
    localparam int Off   = $clog2(StrbW);
    localparam int IW    = NumWords > 1 ? $clog2(NumWords) : 1;
    localparam int PW    = NrPorts > 1 ? $clog2(NrPorts) : 1;
    localparam int CW    = $clog2(RspDepth + 1);
    localparam int FW    = RspDepth > 1 ? $clog2(RspDepth) : 1;

    typedef struct packed {
        logic                 v;
        logic [PW-1:0]        port;
        logic [DataWidth-1:0] data;
        logic                 err;
    } ent_t;

    logic [DataWidth-1:0] mem [NumWords];
    logic [NrPorts-1:0]   elig;
    logic [PW-1:0]        ptr_q, ptr_d, win, cand;
    logic                 grant, wr, in_rng;
    logic [AddrWidth-1:0] addr, rel, widx;
    logic [DataWidth-1:0] wdata;
    logic [StrbW-1:0]     wstrb;
    ent_t                 s, po;

    // Scan from the pointer downwards so the closest eligible port wins last.
    always_comb begin
        grant = 1'b0;
        win   = ptr_q;
        cand  = '0;
        for (int k = NrPorts - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr_q) + k) % int'(NrPorts));
            if (elig[cand] && !rst_i) begin
                grant = 1'b1;
                win   = cand;
            end
        end
        q_ready_o = '0;
        if (grant) q_ready_o[win] = 1'b1;
        ptr_d = grant ? (win == PW'(NrPorts - 1) ? '0 : win + 1'b1) : ptr_q;
    end

    always_comb begin
        addr   = q_addr_i[win*AddrWidth +: AddrWidth];
        wr     = q_write_i[win];
        wdata  = q_data_i[win*DataWidth +: DataWidth];
        wstrb  = q_strb_i[win*StrbW +: StrbW];
        rel    = addr - BaseAddr;
        widx   = rel >> Off;
        in_rng = (addr >= BaseAddr) && (widx < AddrWidth'(NumWords));
        s.v    = grant;
        s.port = win;
        s.err  = !in_rng;
        s.data = (in_rng && !wr) ? mem[widx[IW-1:0]] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (grant && wr && in_rng)
            for (int b = 0; b < StrbW; b++)
                if (wstrb[b]) mem[widx[IW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
    end

    generate
        if (Latency == 1) begin : g_nopipe
            assign po = s;
        end else begin : g_pipe
            ent_t pipe_q [Latency-1];
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int k = 0; k < Latency - 1; k++) pipe_q[k] <= '0;
                end else begin
                    pipe_q[0] <= s;
                    for (int k = 1; k < Latency - 1; k++) pipe_q[k] <= pipe_q[k-1];
                end
            end
            assign po = pipe_q[Latency-2];
        end
    endgenerate

    for (genvar i = 0; i < NrPorts; i++) begin : g_port
        logic [DataWidth:0] buf_q [RspDepth];
        logic [FW-1:0]      rd_q, wr_q;
        logic [CW-1:0]      cnt_q, out_q;
        logic               push, pop;
        assign push    = po.v && (po.port == PW'(i));
        assign pop     = p_valid_o[i] && p_ready_i[i];
        assign elig[i] = q_valid_i[i] && (out_q < CW'(RspDepth));
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rd_q  <= '0;
                wr_q  <= '0;
                cnt_q <= '0;
                out_q <= '0;
            end else begin
                if (push) begin
                    buf_q[wr_q] <= {po.err, po.data};
                    wr_q        <= (wr_q == FW'(RspDepth - 1)) ? '0 : wr_q + 1'b1;
                end
                if (pop) rd_q <= (rd_q == FW'(RspDepth - 1)) ? '0 : rd_q + 1'b1;
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
                out_q <= out_q + CW'(q_ready_o[i]) - CW'(pop);
            end
        end
        assign p_valid_o[i]                      = cnt_q != '0;
        assign p_data_o[i*DataWidth +: DataWidth] = p_valid_o[i] ? buf_q[rd_q][DataWidth-1:0] : '0;
        assign p_error_o[i]                      = p_valid_o[i] && buf_q[rd_q][DataWidth];
    end
endmodule

// File: tb/tb_tb_mem_multiport.sv
// tb_tb_mem_multiport: directed scenarios for tb_mem_multiport with a per-port
// scoreboard fed from a word model at request handshake.
module tb_tb_mem_multiport;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   q_valid = '0;
    logic [1:0]   q_ready_o;
    logic [63:0]  q_addr = '0;
    logic [1:0]   q_write = '0;
    logic [127:0] q_data = '0;
    logic [15:0]  q_strb = '0;
    logic [1:0]   p_valid_o;
    logic [1:0]   p_ready = 2'b11;
    logic [127:0] p_data_o;
    logic [1:0]   p_error_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [64:0] sb [2][$];
    logic [63:0] model [int];
    logic [64:0] e;
    logic [31:0] a;
    logic [63:0] w;
    int          idx;
    logic        inr;

    tb_mem_multiport #(
        .NrPorts(2), .AddrWidth(32), .DataWidth(64), .NumWords(1024),
        .BaseAddr(32'h8000_0000), .Latency(2), .RspDepth(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .q_valid_i(q_valid), .q_ready_o(q_ready_o), .q_addr_i(q_addr),
        .q_write_i(q_write), .q_data_i(q_data), .q_strb_i(q_strb),
        .p_valid_o(p_valid_o), .p_ready_i(p_ready),
        .p_data_o(p_data_o), .p_error_o(p_error_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // Responses are checked before this cycle's request updates the model.
    always @(negedge clk) begin
        if (rst) begin
            sb[0].delete();
            sb[1].delete();
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (p_valid_o[p] && p_ready[p]) begin
                    checks++;
                    if (sb[p].size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected port %0d: got err=%b data=%h, required no response",
                                 p, p_error_o[p], p_data_o[p*64 +: 64]);
                    end else begin
                        e = sb[p].pop_front();
                        if ({p_error_o[p], p_data_o[p*64 +: 64]} !== e) begin
                            errors++;
                            $display("FAIL sb_rsp port %0d: got err=%b data=%h, required err=%b data=%h",
                                     p, p_error_o[p], p_data_o[p*64 +: 64], e[64], e[63:0]);
                        end
                    end
                end
                if (q_valid[p] && q_ready_o[p]) begin
                    a   = q_addr[p*32 +: 32];
                    inr = (a >= BASE) && (((a - BASE) >> 3) < 32'd1024);
                    idx = int'((a - BASE) >> 3);
                    if (!inr) e = {1'b1, 64'h0};
                    else if (q_write[p]) begin
                        e = {1'b0, 64'h0};
                        w = model.exists(idx) ? model[idx] : 64'h0;
                        for (int b = 0; b < 8; b++)
                            if (q_strb[p*8 + b]) w[b*8 +: 8] = q_data[p*64 + b*8 +: 8];
                        model[idx] = w;
                    end else e = {1'b0, model.exists(idx) ? model[idx] : 64'h0};
                    sb[p].push_back(e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input int p, input bit wr, input logic [31:0] ad,
                       input logic [63:0] d, input logic [7:0] st, output int hs);
        @(posedge clk); #1;
        q_addr[p*32 +: 32] = ad;
        q_write[p]         = wr;
        q_data[p*64 +: 64] = d;
        q_strb[p*8 +: 8]   = st;
        q_valid[p]         = 1'b1;
        hs = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (q_ready_o[p]) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout port %0d: got no grant, required grant within 50 cycles", p);
        end
        @(posedge clk); #1;
        q_valid[p] = 1'b0;
    endtask

    task automatic wait_rsp(input int p, output int c);
        c = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (p_valid_o[p]) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout port %0d: got no response, required one within 20 cycles", p);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        q_valid = 2'b11;
        q_addr = {BASE, BASE};
        @(negedge clk);
        checks++;
        if (q_ready_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 00", q_ready_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({p_valid_o, p_error_o, p_data_o} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got valid=%b err=%b data=%h, required all 0",
                     p_valid_o, p_error_o, p_data_o);
        end
        @(posedge clk); #1;
        q_valid = 2'b00;
        rst = 1'b0;
    endtask

    task automatic test_init;
        int hs;
        for (int k = 0; k < 8; k++)
            req(0, 1'b1, BASE + 32'(k * 8), {32'hA5A5_0000 + 32'(k), 32'h0000_5A5A + 32'(k)}, 8'hFF, hs);
        for (int k = 0; k < 8; k++)
            req(k % 2, 1'b0, BASE + 32'(k * 8), 64'h0, 8'h00, hs);
        idle(6);
    endtask

    task automatic test_write_read;
        int hs, r;
        req(0, 1'b1, 32'h8000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF, hs);
        req(1, 1'b0, 32'h8000_0010, 64'h0, 8'h00, hs);
        wait_rsp(1, r);
        checks++;
        if (r - hs != 2) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required 2", r - hs);
        end
        checks++;
        if (p_data_o[127:64] !== 64'hDEAD_BEEF_0123_4567 || p_error_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_data: got err=%b data=%h, required err=0 data=deadbeef01234567",
                     p_error_o[1], p_data_o[127:64]);
        end
        idle(4);
    endtask

    task automatic test_strobe;
        int hs, r;
        req(0, 1'b1, 32'h8000_0030, 64'h0, 8'hFF, hs);
        req(0, 1'b1, 32'h8000_0030, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, hs);
        idle(4);
        req(1, 1'b0, 32'h8000_0030, 64'h0, 8'h00, hs);
        wait_rsp(1, r);
        checks++;
        if (p_data_o[127:64] !== 64'h0000_0000_FFFF_FFFF) begin
            errors++;
            $display("FAIL strobe: got %h, required 00000000ffffffff", p_data_o[127:64]);
        end
        idle(4);
    endtask

    task automatic test_round_robin;
        logic [1:0] exp;
        @(posedge clk); #1;
        rst = 1'b1;
        q_addr = {BASE + 32'h8, BASE};
        q_write = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        q_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (q_ready_o !== exp) begin
                errors++;
                $display("FAIL rr_grant step %0d: got %b, required %b", k, q_ready_o, exp);
            end
        end
        @(posedge clk); #1;
        q_valid = 2'b00;
        idle(6);
    endtask

    task automatic test_backpressure;
        int n, r, g;
        @(posedge clk); #1;
        p_ready[0] = 1'b0;
        q_addr[31:0] = BASE;
        q_write[0] = 1'b0;
        q_valid[0] = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (q_ready_o[0]) n++;
            @(posedge clk); #1;
            q_addr[31:0] = BASE + 32'((n % 4) * 8);
        end
        @(negedge clk);
        checks++;
        if (n != 4 || q_ready_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL credit_limit: got %0d handshakes ready=%b, required 4 and ready=0", n, q_ready_o[0]);
        end
        @(posedge clk); #1;
        p_ready[0] = 1'b1;
        r = -1;
        g = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (p_valid_o[0] && r < 0) r = cyc;
            if (q_ready_o[0]) begin
                g = cyc;
                break;
            end
        end
        checks++;
        if (r < 0 || g != r + 1) begin
            errors++;
            $display("FAIL credit_return: got grant cycle %0d, first response cycle %0d, required grant = response + 1", g, r);
        end
        @(posedge clk); #1;
        q_valid[0] = 1'b0;
        idle(8);
    endtask

    task automatic test_errors;
        int hs, r;
        req(0, 1'b0, 32'h7FFF_FFF8, 64'h0, 8'h00, hs);
        wait_rsp(0, r);
        checks++;
        if (p_error_o[0] !== 1'b1 || p_data_o[63:0] !== 64'h0) begin
            errors++;
            $display("FAIL err_low: got err=%b data=%h, required err=1 data=0", p_error_o[0], p_data_o[63:0]);
        end
        req(1, 1'b0, 32'h8000_2000, 64'h0, 8'h00, hs);
        wait_rsp(1, r);
        checks++;
        if (p_error_o[1] !== 1'b1 || p_data_o[127:64] !== 64'h0) begin
            errors++;
            $display("FAIL err_high: got err=%b data=%h, required err=1 data=0", p_error_o[1], p_data_o[127:64]);
        end
        req(0, 1'b1, 32'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, hs);
        wait_rsp(0, r);
        checks++;
        if (p_error_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL err_write: got err=%b, required 1", p_error_o[0]);
        end
        for (int k = 0; k < 8; k++)
            req(k % 2, 1'b0, BASE + 32'(k * 8), 64'h0, 8'h00, hs);
        idle(6);
    endtask

    task automatic test_reset_mid;
        int hs, n, r;
        req(1, 1'b1, 32'h8000_0020, 64'h0BAD_F00D_CAFE_1234, 8'hFF, hs);
        idle(4);
        p_ready[1] = 1'b0;
        q_addr[63:32] = BASE;
        q_write[1] = 1'b0;
        q_valid[1] = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (q_ready_o[1]) n++;
            if (n == 3) break;
        end
        @(posedge clk); #1;
        q_valid[1] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (n != 3 || p_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_valid: got valid=%b after %0d reads, required 00 after 3", p_valid_o, n);
        end
        @(posedge clk); #1;
        q_valid[1] = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (q_ready_o[1]) n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL reset_mid_credits: got %0d handshakes, required 4", n);
        end
        @(posedge clk); #1;
        q_valid[1] = 1'b0;
        p_ready[1] = 1'b1;
        idle(8);
        req(0, 1'b0, 32'h8000_0020, 64'h0, 8'h00, hs);
        wait_rsp(0, r);
        checks++;
        if (p_data_o[63:0] !== 64'h0BAD_F00D_CAFE_1234) begin
            errors++;
            $display("FAIL reset_keeps_mem: got %h, required 0badf00dcafe1234", p_data_o[63:0]);
        end
        idle(6);
    endtask

    initial begin
        test_reset;
        test_init;
        test_write_read;
        test_strobe;
        test_round_robin;
        test_backpressure;
        test_errors;
        test_reset_mid;
        checks++;
        if (sb[0].size() + sb[1].size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending responses, required 0", sb[0].size() + sb[1].size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
